// File: rtl/c64_clk_pkg.sv
// rtl/c64_clk_pkg.sv - shared types and default constants for the C64 clock/reset generator
package c64_clk_pkg;

  // Reset/run sequencing states
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } c64_state_e;

  localparam int          C64_CYC_LEN  = 32;
  localparam logic [15:0] C64_RST_HOLD = 16'd32768;
  localparam int          C64_CYC_W    = 5;

endpackage

// File: rtl/c64_sync_bit.sv
// rtl/c64_sync_bit.sv - SYNC_STAGES-deep single-bit synchroniser with async clear
module c64_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw input one stage deeper into the chain each clock
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // Chain register, cleared by the asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/c64_clk_rst_gen.sv
// rtl/c64_clk_rst_gen.sv - C64 reset stretcher, bus-cycle counter and phi0 enables (optional C64_TURBO_EN)
import c64_clk_pkg::*;

module c64_clk_rst_gen #(
  parameter logic [15:0] RST_HOLD    = C64_RST_HOLD,
  parameter int          CYC_LEN     = C64_CYC_LEN,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 clk32,
  input  logic                 reset,
  input  logic                 pll_locked,
  input  logic                 reset_req,
`ifdef C64_TURBO_EN
  input  logic                 turbo,
`endif
  output logic                 sys_reset,
  output logic                 running,
  output logic [C64_CYC_W-1:0] sys_cycle,
  output logic                 phi0,
  output logic                 ce_phi0_rise,
  output logic                 ce_phi0_fall
);

  localparam logic [15:0]          HOLD_LAST = RST_HOLD - 16'd1;
  localparam logic [C64_CYC_W-1:0] N_LAST    = C64_CYC_W'(CYC_LEN - 1);
  localparam logic [C64_CYC_W-1:0] N_RISE    = C64_CYC_W'(CYC_LEN / 2 - 1);
  localparam logic [C64_CYC_W-1:0] N_HALF    = C64_CYC_W'(CYC_LEN / 2);

  logic                 locked_s;
  c64_state_e           state_q, state_d;
  logic [15:0]          hold_cnt_q, hold_cnt_d;
  logic [C64_CYC_W-1:0] sys_cycle_q, sys_cycle_d;
  logic                 sys_reset_q, sys_reset_d;
  logic                 running_q, running_d;
  logic [C64_CYC_W-1:0] cyc_last, cyc_rise, cyc_half;
  logic                 cyc_wrap;

  c64_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk32),
    .rst (reset),
    .d   (pll_locked),
    .q   (locked_s)
  );

`ifdef C64_TURBO_EN
  localparam logic [C64_CYC_W-1:0] T_LAST = C64_CYC_W'(CYC_LEN / 2 - 1);
  localparam logic [C64_CYC_W-1:0] T_RISE = C64_CYC_W'(CYC_LEN / 4 - 1);
  localparam logic [C64_CYC_W-1:0] T_HALF = C64_CYC_W'(CYC_LEN / 4);

  logic turbo_q, turbo_d;

  // Thresholds follow the latched turbo mode so a running cycle keeps its length
  always_comb begin
    cyc_last = turbo_q ? T_LAST : N_LAST;
    cyc_rise = turbo_q ? T_RISE : N_RISE;
    cyc_half = turbo_q ? T_HALF : N_HALF;
  end

  // Sample turbo only when a new bus cycle starts (RUN entry or wrap to 0)
  always_comb begin
    turbo_d = turbo_q;
    if (state_d == RUN && (state_q != RUN || cyc_wrap)) turbo_d = turbo;
  end

  // Latched turbo mode
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) turbo_q <= 1'b0;
    else       turbo_q <= turbo_d;
  end
`else
  // Fixed-length bus cycle thresholds
  always_comb begin
    cyc_last = N_LAST;
    cyc_rise = N_RISE;
    cyc_half = N_HALF;
  end
`endif

  assign cyc_wrap = (sys_cycle_q == cyc_last);

  // Next-state and hold-counter logic; lock loss always beats a reset request
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        hold_cnt_d = '0;
        if (locked_s) state_d = HOLD;
      end
      HOLD: begin
        if (!locked_s) begin
          state_d    = WAIT_LOCK;
          hold_cnt_d = '0;
        end else if (reset_req) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end
      RUN: begin
        hold_cnt_d = '0;
        if (!locked_s)      state_d = WAIT_LOCK;
        else if (reset_req) state_d = HOLD;
      end
      default: begin
        state_d    = WAIT_LOCK;
        hold_cnt_d = '0;
      end
    endcase
    sys_reset_d = (state_d != RUN);
    running_d   = (state_d == RUN);
  end

  // Bus-cycle position: counts only while staying in RUN, so RUN entry shows 0
  always_comb begin
    sys_cycle_d = '0;
    if (state_q == RUN && state_d == RUN) begin
      sys_cycle_d = cyc_wrap ? '0 : sys_cycle_q + C64_CYC_W'(1);
    end
  end

  // State, counters and registered reset/run flags
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_LOCK;
      hold_cnt_q  <= '0;
      sys_cycle_q <= '0;
      sys_reset_q <= 1'b1;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      sys_cycle_q <= sys_cycle_d;
      sys_reset_q <= sys_reset_d;
      running_q   <= running_d;
    end
  end

  assign sys_reset    = sys_reset_q;
  assign running      = running_q;
  assign sys_cycle    = sys_cycle_q;
  assign phi0         = running_q && (sys_cycle_q >= cyc_half);
  assign ce_phi0_rise = running_q && (sys_cycle_q == cyc_rise);
  assign ce_phi0_fall = running_q && cyc_wrap;

endmodule

// File: tb/tb_c64_clk_rst_gen.sv
// tb/tb_c64_clk_rst_gen.sv - scoreboard bench for c64_clk_rst_gen (turbo steps under C64_TURBO_EN)
module tb_c64_clk_rst_gen;

  localparam int CYC = 32;

  logic       clk32 = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       reset_req;
`ifdef C64_TURBO_EN
  logic       turbo;
`endif
  logic       sys_reset;
  logic       running;
  logic [4:0] sys_cycle;
  logic       phi0;
  logic       ce_phi0_rise;
  logic       ce_phi0_fall;

  c64_clk_rst_gen #(
    .RST_HOLD    (16'd8),
    .CYC_LEN     (CYC),
    .SYNC_STAGES (2)
  ) dut (
    .clk32        (clk32),
    .reset        (reset),
    .pll_locked   (pll_locked),
    .reset_req    (reset_req),
`ifdef C64_TURBO_EN
    .turbo        (turbo),
`endif
    .sys_reset    (sys_reset),
    .running      (running),
    .sys_cycle    (sys_cycle),
    .phi0         (phi0),
    .ce_phi0_rise (ce_phi0_rise),
    .ce_phi0_fall (ce_phi0_fall)
  );

  always #5 clk32 = ~clk32;

  typedef struct {
    string      tag;
    logic [9:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Expected output vector {sys_reset, running, sys_cycle, phi0, rise, fall}
  function automatic logic [9:0] model(input logic run, input logic [4:0] cyc, input int len);
    logic [9:0] r;
    int         c;
    c    = int'(cyc);
    r    = '0;
    r[9] = !run;
    r[8] = run;
    if (run) begin
      r[7:3] = cyc;
      r[2]   = (c >= len / 2);
      r[1]   = (c == len / 2 - 1);
      r[0]   = (c == len - 1);
    end
    return r;
  endfunction

  task automatic check_pop();
    exp_t       e;
    logic [9:0] obs;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_empty: observed 0 entries required 1");
      return;
    end
    e   = sb.pop_front();
    obs = {sys_reset, running, sys_cycle, phi0, ce_phi0_rise, ce_phi0_fall};
    n_tests++;
    assert (obs === e.v) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", e.tag, obs, e.v);
    end
  endtask

  task automatic step(input string tag, input logic run, input logic [4:0] cyc, input int len);
    exp_t e;
    e.tag = tag;
    e.v   = model(run, cyc, len);
    sb.push_back(e);
    @(posedge clk32);
    #1;
    check_pop();
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 5'd0, CYC);
  endtask

  task automatic run_cyc(input string tag, input int start, input int n, input int len);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 5'((start + i) % len), len);
  endtask

  initial begin
    exp_t e;
    reset      = 1'b1;
    pll_locked = 1'b0;
    reset_req  = 1'b0;
`ifdef C64_TURBO_EN
    turbo      = 1'b0;
`endif
    idle("in_reset", 3);
    reset = 1'b0;
    idle("no_lock", 50);

    pll_locked = 1'b1;
    idle("lock_sync", 2);
    idle("lock_hold", 8);
    run_cyc("run3", 0, 3 * CYC, CYC);

    run_cyc("pre_drop", 0, 21, CYC);
    pll_locked = 1'b0;
    run_cyc("drop_latency", 21, 2, CYC);
    idle("lock_lost", 20);

    pll_locked = 1'b1;
    idle("relock_sync", 2);
    idle("relock_hold", 8);
    run_cyc("relock_run", 0, 5, CYC);

    reset_req = 1'b1;
    idle("req_hold", 1);
    reset_req = 1'b0;
    idle("req_hold", 7);
    run_cyc("req_run", 0, 6, CYC);

    reset_req = 1'b1;
    idle("rereq_hold", 1);
    reset_req = 1'b0;
    idle("rereq_hold", 5);
    reset_req = 1'b1;
    idle("rereq_restart", 1);
    reset_req = 1'b0;
    idle("rereq_restart", 7);
    run_cyc("rereq_run", 0, 40, CYC);

`ifdef C64_TURBO_EN
    run_cyc("pre_turbo", 8, 3, CYC);
    turbo = 1'b1;
    run_cyc("turbo_cur", 11, 21, CYC);
    run_cyc("turbo_short", 0, 48, CYC / 2);
`endif

    reset = 1'b1;
    #1;
    e.tag = "async_reset";
    e.v   = model(1'b0, 5'd0, CYC);
    sb.push_back(e);
    check_pop();
    idle("held_reset", 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
